// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin merge of FIFO4..7 into one lane-tagged valid/ready stream with per-lane delivered-word counters
module egress_arbiter #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 5,
  parameter int BUF_D  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        empty_in,
  input  logic [DATA_W-1:0] FIFO_data_in4,
  input  logic [DATA_W-1:0] FIFO_data_in5,
  input  logic [DATA_W-1:0] FIFO_data_in6,
  input  logic [DATA_W-1:0] FIFO_data_in7,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        lane_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic [1:0]        idx,
  input  logic              req,
  output logic              valid_contador,
  output logic [CNT_W-1:0]  contador_out,
  output logic              idle_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [1:0] DEPTH = BUF_D[1:0];
  state_t state, state_n;
  logic [DATA_W-1:0] d0, d1, nd0, nd1, cap;
  logic [1:0] l0, l1, nl0, nl1, rr, gnt, c1, c2, c3, inf_lane, occ, post, nocc;
  logic [3:0] ne;
  logic inf, hand, go;
  logic [CNT_W-1:0] count [4];
  assign ne = ~empty_in;
  assign c1 = rr + 2'd1;
  assign c2 = rr + 2'd2;
  assign c3 = rr + 2'd3;
  assign gnt = ne[c1] ? c1 : ne[c2] ? c2 : ne[c3] ? c3 : rr;
  assign valid_out = occ != 2'd0;
  assign data_out = d0;
  assign lane_out = l0;
  assign hand = valid_out & ready_in;
  assign idle_out = state == IDLE;
  assign cap = inf_lane == 2'd0 ? FIFO_data_in4 : inf_lane == 2'd1 ? FIFO_data_in5 :
               inf_lane == 2'd2 ? FIFO_data_in6 : FIFO_data_in7;
  // occupancy after this cycle's handoff and capture; the pop issued now lands in flight on top of it
  assign post = occ - {1'b0, hand};
  assign nocc = post + {1'b0, inf};
  assign go = state == RUN && |ne && nocc < DEPTH;
  assign pop = go ? 4'b0001 << gnt : 4'b0000;
  always_comb begin
    nd0 = hand ? d1 : d0;
    nl0 = hand ? l1 : l0;
    nd1 = d1;
    nl1 = l1;
    if (inf && post == 2'd0) begin
      nd0 = cap;
      nl0 = inf_lane;
    end
    if (inf && post != 2'd0) begin
      nd1 = cap;
      nl1 = inf_lane;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (enable ? RUN : IDLE) :
              enable ? RUN :
              state == RUN ? DRAIN :
              nocc == 2'd0 ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d0 <= '0;
      d1 <= '0;
      l0 <= '0;
      l1 <= '0;
      occ <= '0;
      inf <= 1'b0;
      inf_lane <= '0;
      rr <= 2'd3;
      valid_contador <= 1'b0;
      contador_out <= '0;
      for (int i = 0; i < 4; i++) count[i] <= '0;
    end else begin
      state <= state_n;
      d0 <= nd0;
      d1 <= nd1;
      l0 <= nl0;
      l1 <= nl1;
      occ <= nocc;
      inf <= go;
      if (go) begin
        inf_lane <= gnt;
        rr <= gnt;
      end
      if (hand && count[l0] != '1) count[l0] <= count[l0] + 1'b1;
      valid_contador <= req;
      if (req) contador_out <= count[idx];
    end
  end
endmodule
